// File: rtl/urv_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// architectural bit positions inside mstatus/mie/mip, interrupt cause codes
// and the trap-sequencing state type.
package urv_trap_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CAUSE_W    = 4;

  // CSR addresses
  localparam logic [CSR_ADDR_W-1:0] CSR_ID_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_ID_MIE     = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_ID_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_ID_MCAUSE  = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_ID_MIP     = 12'h344;

  // Bit positions of the implemented fields
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIX_MEI_BIT      = 11;
  localparam int unsigned MIX_MTI_BIT      = 7;

  // Interrupt cause codes (mcause[3:0] with mcause[31] set)
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ_EXT   = 4'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ_TIMER = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } trap_state_t;

endpackage

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap/interrupt controller. Owns mstatus, mie, mip, mepc and
// mcause, sequences exception/interrupt entry and mret, and raises the
// pipeline's interrupt request and trap-redirect pulse.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   x_stall_i, x_kill_i     X-stage stall / cancel; either blocks commit
//   d_is_csr_i, d_csr_sel_i, x_csr_write_value_i   CSR write from the CSR unit
//   d_is_mret_i             mret in X
//   x_pc_i                  PC of the X instruction (saved to mepc on trap)
//   x_exception_i, x_exception_cause_i   synchronous exception and its cause
//   irq_ext_i, irq_timer_i  level interrupt pins
//   x_irq_o                 interrupt request (trap taken at next commit)
//   x_trap_o                one-cycle pulse after a trap commits
//   csr_*_o                 CSR read values
module urv_trap_ctrl
  import urv_trap_ctrl_pkg::*;
#(
  parameter int unsigned g_with_timer_irq = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  x_stall_i,
  input  logic                  x_kill_i,
  input  logic                  d_is_csr_i,
  input  logic [CSR_ADDR_W-1:0] d_csr_sel_i,
  input  logic [XLEN-1:0]       x_csr_write_value_i,
  input  logic                  d_is_mret_i,
  input  logic [XLEN-1:0]       x_pc_i,
  input  logic                  x_exception_i,
  input  logic [CAUSE_W-1:0]    x_exception_cause_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  output logic                  x_irq_o,
  output logic                  x_trap_o,
  output logic [XLEN-1:0]       csr_mstatus_o,
  output logic [XLEN-1:0]       csr_mip_o,
  output logic [XLEN-1:0]       csr_mie_o,
  output logic [XLEN-1:0]       csr_mepc_o,
  output logic [XLEN-1:0]       csr_mcause_o
);

  localparam bit TIMER_EN = (g_with_timer_irq != 0);

  trap_state_t          state;
  logic                 st_mie, st_mpie;
  logic                 ie_mei, ie_mti;
  logic                 ip_mei, ip_mti;
  logic [XLEN-3:0]      epc;
  logic                 cause_irq;
  logic [CAUSE_W-1:0]   cause_code;

  logic commit, csr_we;
  logic wr_mstatus, wr_mie, wr_mepc, wr_mcause;
  logic pending, exc_take, irq_take, trap_take, mret_take;
  logic unused;

  // Commit qualification and trap decisions
  assign commit     = !x_stall_i && !x_kill_i;
  assign csr_we     = commit && d_is_csr_i;
  assign wr_mstatus = csr_we && (d_csr_sel_i == CSR_ID_MSTATUS);
  assign wr_mie     = csr_we && (d_csr_sel_i == CSR_ID_MIE);
  assign wr_mepc    = csr_we && (d_csr_sel_i == CSR_ID_MEPC);
  assign wr_mcause  = csr_we && (d_csr_sel_i == CSR_ID_MCAUSE);

  assign pending   = ((ip_mei && ie_mei) || (ip_mti && ie_mti)) && st_mie;
  assign exc_take  = commit && x_exception_i;
  // An exception committing in ST_REQ pre-empts the interrupt
  assign irq_take  = commit && (state == ST_REQ) && pending && !x_exception_i;
  assign trap_take = exc_take || irq_take;
  assign mret_take = commit && d_is_mret_i && !x_exception_i;

  // Word alignment of mepc makes the low PC bits irrelevant
  assign unused = ^x_pc_i[1:0];

  // CSR read views; unimplemented bits read as zero
  always_comb begin
    csr_mstatus_o = '0;
    csr_mstatus_o[MSTATUS_MIE_BIT]  = st_mie;
    csr_mstatus_o[MSTATUS_MPIE_BIT] = st_mpie;
    csr_mie_o = '0;
    csr_mie_o[MIX_MEI_BIT] = ie_mei;
    csr_mie_o[MIX_MTI_BIT] = ie_mti;
    csr_mip_o = '0;
    csr_mip_o[MIX_MEI_BIT] = ip_mei;
    csr_mip_o[MIX_MTI_BIT] = ip_mti;
    csr_mepc_o   = {epc, 2'b00};
    csr_mcause_o = {cause_irq, {(XLEN-1-CAUSE_W){1'b0}}, cause_code};
  end

  // CSR state, trap entry/return and request sequencing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      ie_mei     <= 1'b0;
      ie_mti     <= 1'b0;
      ip_mei     <= 1'b0;
      ip_mti     <= 1'b0;
      epc        <= '0;
      cause_irq  <= 1'b0;
      cause_code <= '0;
      x_irq_o    <= 1'b0;
      x_trap_o   <= 1'b0;
    end else begin
      // Pins are sampled once; with the timer disabled MTIP stays 0
      ip_mei <= irq_ext_i;
      ip_mti <= TIMER_EN && irq_timer_i;

      // mie writes apply even in a trapping cycle
      if (wr_mie) begin
        ie_mei <= x_csr_write_value_i[MIX_MEI_BIT];
        ie_mti <= TIMER_EN && x_csr_write_value_i[MIX_MTI_BIT];
      end

      if (trap_take) begin
        epc     <= x_pc_i[XLEN-1:2];
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
        if (exc_take) begin
          cause_irq  <= 1'b0;
          cause_code <= x_exception_cause_i;
        end else begin
          cause_irq  <= 1'b1;
          cause_code <= (ip_mei && ie_mei) ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
        end
      end else begin
        if (wr_mstatus) begin
          st_mie  <= x_csr_write_value_i[MSTATUS_MIE_BIT];
          st_mpie <= x_csr_write_value_i[MSTATUS_MPIE_BIT];
        end
        if (mret_take) begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
        end
        if (wr_mepc) begin
          epc <= x_csr_write_value_i[XLEN-1:2];
        end
        if (wr_mcause) begin
          cause_irq  <= x_csr_write_value_i[XLEN-1];
          cause_code <= x_csr_write_value_i[CAUSE_W-1:0];
        end
      end

      x_trap_o <= trap_take;
      x_irq_o  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (exc_take) begin
            state <= ST_FLUSH;
          end else if (pending) begin
            state   <= ST_REQ;
            x_irq_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (trap_take) begin
            state <= ST_FLUSH;
          end else if (!pending) begin
            state <= ST_IDLE;
          end else begin
            x_irq_o <= 1'b1;
          end
        end
        // One quiet cycle so the pipeline can redirect
        ST_FLUSH: begin
          state <= exc_take ? ST_FLUSH : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
